// File: rtl/tff_updown_counter_pkg.sv
// Shared types and elaboration helpers for the T-cell up/down counter.
package tff_pkg;

    typedef enum logic {DN = 1'b0, UP = 1'b1} dir_e;

    // Bits needed to represent 0..v-1, never less than one.
    function automatic int clog2_min(input int unsigned v);
        int r;
        if (v <= 32'd2) begin
            r = 1;
        end else begin
            r = $clog2(v);
        end
        return r;
    endfunction

endpackage

// File: rtl/tff_updown_counter_if.sv
// Control and status bundle of the up/down counter.
interface tff_updown_counter_if #(
    parameter int WIDTH = 8
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             up_dn;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;
    logic             ovf;

    modport master (
        output clear, load, load_val, en, up_dn,
        input  q, tc, wrap, ovf
    );

    modport slave (
        input  clear, load, load_val, en, up_dn,
        output q, tc, wrap, ovf
    );
endinterface

// File: rtl/tff_updown_counter_cell.sv
// One counter bit: a T flip-flop with synchronous clear and parallel load.
module tff_cell (
    input  logic clk,
    input  logic reset_n,
    input  logic t,
    input  logic sync_clr,
    input  logic ld,
    input  logic d,
    output logic q
);
    logic q_q;
    logic q_d;

    // Next bit value: clear beats load beats toggle.
    always_comb begin
        q_d = q_q;
        if (sync_clr) begin
            q_d = 1'b0;
        end else if (ld) begin
            q_d = d;
        end else begin
            q_d = q_q ^ t;
        end
    end

    // Bit storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/tff_updown_counter.sv
// Modulo-N up/down counter built from T-cells, with wrap pulse and sticky overflow.
module tff_updown_counter
    import tff_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter int SATURATE = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    tff_updown_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

    if ((clog2_min(MODULUS) > WIDTH) || (MODULUS < 2)) begin : g_bad_modulus
        $error("tff_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] t_s;
    logic [WIDTH-1:0] ld_val_s;
    dir_e             dir_s;
    logic             tc_s;
    logic             wrap_d;
    logic             wrap_q;
    logic             ovf_d;
    logic             ovf_q;

    // Direction, terminal count and clamped load value.
    always_comb begin
        dir_s = dir_e'(bus.up_dn);
        if (dir_s == UP) begin
            tc_s = (q_s == MAX_C);
        end else begin
            tc_s = (q_s == ZERO_C);
        end
        if (bus.load_val > MAX_C) begin
            ld_val_s = MAX_C;
        end else begin
            ld_val_s = bus.load_val;
        end
    end

    // Target count and flag updates; toggles are the bits that differ from q.
    always_comb begin
        q_d    = q_s;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;
        if (bus.clear) begin
            q_d   = ZERO_C;
            ovf_d = 1'b0;
        end else if (bus.load) begin
            q_d = ld_val_s;
        end else if (bus.en) begin
            if (!tc_s) begin
                q_d = (dir_s == UP) ? (q_s + ONE_C) : (q_s - ONE_C);
            end else if (SATURATE != 32'sd0) begin
                ovf_d = 1'b1;
            end else begin
                q_d    = (dir_s == UP) ? ZERO_C : MAX_C;
                wrap_d = 1'b1;
            end
        end else begin
            q_d = q_s;
        end
        t_s = q_s ^ q_d;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk      (clk),
            .reset_n  (reset_n),
            .t        (t_s[i]),
            .sync_clr (bus.clear),
            .ld       (bus.load),
            .d        (ld_val_s[i]),
            .q        (q_s[i])
        );
    end

    // Wrap pulse and sticky overflow registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.q    = q_s;
    assign bus.tc   = tc_s;
    assign bus.wrap = wrap_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_tff_updown_counter.sv
// Checks wrap (4b/mod10), saturate (4b/mod10) and natural-overflow (8b/mod256) counters.
module tb_tff_updown_counter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clr, ld, en, up;
    logic [7:0] lv;

    always #5 clk = ~clk;

    tff_updown_counter_if #(.WIDTH(4)) ifa ();
    tff_updown_counter_if #(.WIDTH(4)) ifb ();
    tff_updown_counter_if #(.WIDTH(8)) ifc ();

    assign ifa.clear = clr;  assign ifa.load = ld;  assign ifa.load_val = lv[3:0];
    assign ifa.en    = en;   assign ifa.up_dn = up;
    assign ifb.clear = clr;  assign ifb.load = ld;  assign ifb.load_val = lv[3:0];
    assign ifb.en    = en;   assign ifb.up_dn = up;
    assign ifc.clear = clr;  assign ifc.load = ld;  assign ifc.load_val = lv;
    assign ifc.en    = en;   assign ifc.up_dn = up;

    tff_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa.slave));
    tff_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb.slave));
    tff_updown_counter #(.WIDTH(8), .MODULUS(256), .SATURATE(0)) dut_c (
        .clk(clk), .reset_n(reset_n), .bus(ifc.slave));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: count value as an integer in 0..M-1, flags as ints.
    int mq[3];
    int mw[3];
    int mo[3];
    int modv[3] = '{10, 10, 256};
    int satv[3] = '{0, 1, 0};

    typedef struct {
        logic       clr, ld;
        logic [7:0] lv;
        logic       en, up;
        int         qa, wa, qb, ob;
    } vec_t;
    vec_t tbl[27];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k] = 0; mw[k] = 0; mo[k] = 0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            int m;
            int v;
            int nxt;
            m = modv[k];
            v = (k == 2) ? int'(lv) : int'(lv[3:0]);
            if (clr) begin
                mq[k] = 0; mw[k] = 0; mo[k] = 0;
            end else if (ld) begin
                mq[k] = (v < m) ? v : m - 1;
                mw[k] = 0;
            end else if (en) begin
                nxt = up ? mq[k] + 1 : mq[k] - 1;
                if (nxt >= 0 && nxt < m) begin
                    mq[k] = nxt; mw[k] = 0;
                end else if (satv[k] != 0) begin
                    mo[k] = 1; mw[k] = 0;
                end else begin
                    mq[k] = (nxt + m) % m; mw[k] = 1;
                end
            end else begin
                mw[k] = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            logic [31:0] aq, atc, aw, ao;
            int          etc;
            case (k)
                0: begin aq = 32'(ifa.q); atc = 32'(ifa.tc); aw = 32'(ifa.wrap); ao = 32'(ifa.ovf); end
                1: begin aq = 32'(ifb.q); atc = 32'(ifb.tc); aw = 32'(ifb.wrap); ao = 32'(ifb.ovf); end
                default: begin aq = 32'(ifc.q); atc = 32'(ifc.tc); aw = 32'(ifc.wrap); ao = 32'(ifc.ovf); end
            endcase
            etc = up ? int'(mq[k] == modv[k] - 1) : int'(mq[k] == 0);
            chk($sformatf("%s_q%0d", tag, k),    aq,  32'(mq[k]));
            chk($sformatf("%s_tc%0d", tag, k),   atc, 32'(etc));
            chk($sformatf("%s_wrap%0d", tag, k), aw,  32'(mw[k]));
            chk($sformatf("%s_ovf%0d", tag, k),  ao,  32'(mo[k]));
        end
    endtask

    task automatic step(input logic c, input logic l, input logic [7:0] v,
                        input logic e, input logic u, input string tag);
        clr = c; ld = l; lv = v; en = e; up = u;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic set_vec(input int i, input logic c, input logic l, input logic [7:0] v,
                           input logic e, input logic u,
                           input int qa, input int wa, input int qb, input int ob);
        tbl[i].clr = c; tbl[i].ld = l; tbl[i].lv = v; tbl[i].en = e; tbl[i].up = u;
        tbl[i].qa = qa; tbl[i].wa = wa; tbl[i].qb = qb; tbl[i].ob = ob;
    endtask

    initial begin
        // Count up 12 from 0: wrap counter passes 9->0, saturating one sticks at 9.
        for (int i = 0; i < 12; i++) begin
            set_vec(i, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, (i + 1) % 10, int'(i == 9),
                    (i + 1 > 9) ? 9 : i + 1, int'(i >= 9));
        end
        set_vec(12, 1'b1, 1'b0, 8'd0,  1'b0, 1'b1, 0, 0, 0, 0);
        set_vec(13, 1'b0, 1'b1, 8'd15, 1'b0, 1'b1, 9, 0, 9, 0);
        set_vec(14, 1'b1, 1'b1, 8'd15, 1'b1, 1'b1, 0, 0, 0, 0);
        set_vec(15, 1'b0, 1'b1, 8'd0,  1'b0, 1'b0, 0, 0, 0, 0);
        set_vec(16, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 9, 1, 0, 1);
        set_vec(17, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 8, 0, 0, 1);
        set_vec(18, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 7, 0, 0, 1);
        set_vec(19, 1'b0, 1'b1, 8'd4,  1'b0, 1'b1, 4, 0, 4, 1);
        set_vec(20, 1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 5, 0, 5, 1);
        set_vec(21, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 4, 0, 4, 1);
        set_vec(22, 1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 5, 0, 5, 1);
        set_vec(23, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 4, 0, 4, 1);
        set_vec(24, 1'b0, 1'b0, 8'd0,  1'b0, 1'b1, 4, 0, 4, 1);
        set_vec(25, 1'b0, 1'b1, 8'd9,  1'b1, 1'b1, 9, 0, 9, 1);
        set_vec(26, 1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 0, 1, 9, 1);

        reset_n = 1'b0;
        clr = 1'b0; ld = 1'b0; lv = 8'd0; en = 1'b0; up = 1'b1;
        model_reset();
        #12;
        check_all("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            step(tbl[i].clr, tbl[i].ld, tbl[i].lv, tbl[i].en, tbl[i].up, $sformatf("vec%0d", i));
            chk($sformatf("tbl%0d_qa", i),  32'(ifa.q),    32'(tbl[i].qa));
            chk($sformatf("tbl%0d_wa", i),  32'(ifa.wrap), 32'(tbl[i].wa));
            chk($sformatf("tbl%0d_qb", i),  32'(ifb.q),    32'(tbl[i].qb));
            chk($sformatf("tbl%0d_ob", i),  32'(ifb.ovf),  32'(tbl[i].ob));
        end

        // Asynchronous reset mid-cycle with q=5 and ovf set on the saturating counter.
        step(1'b0, 1'b1, 8'd5, 1'b1, 1'b1, "preload5");
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        en = 1'b0;
        #2;
        reset_n = 1'b1;
        step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, "rst_release");
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, "rst_first_count");

        for (int n = 0; n < 400; n++) begin
            logic [31:0] r;
            r = $urandom;
            step(($urandom_range(0, 29) == 0), ($urandom_range(0, 11) == 0), r[7:0],
                 ($urandom_range(0, 3) != 0), (n % 64 < 40) ? r[8] | r[9] : r[8] & r[9],
                 "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
